// File: rtl/sign_extend_unit.sv
// Widens an instruction immediate: combinational result (zero latency) plus a
// one-cycle registered copy with valid flag; no backpressure, accepts every cycle.
module sign_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] ext_comb,
  output logic [OUT_W-1:0] ext_q,
  output logic             out_valid,
  output logic             neg_q
);

  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_UPPER  = 2'b11;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] bext;
  logic [OUT_W-1:0] uext;

  logic [OUT_W-1:0] ext_d;
  logic             neg_d;
  logic             out_valid_d;
  logic [OUT_W-1:0] ext_reg_q;
  logic             neg_reg_q;
  logic             out_valid_q;

  assign sext = {{PAD_W{imm[IN_W-1]}}, imm};
  assign zext = {{PAD_W{1'b0}}, imm};
  // Branch offsets are word-aligned; the two top bits of the sign-extended value fall off.
  assign bext = {sext[OUT_W-3:0], 2'b00};
  assign uext = {imm, {PAD_W{1'b0}}};

  always_comb begin
    ext_comb = sext;
    case (mode)
      MODE_SIGN:   ext_comb = sext;
      MODE_ZERO:   ext_comb = zext;
      MODE_BRANCH: ext_comb = bext;
      MODE_UPPER:  ext_comb = uext;
      default:     ext_comb = sext;
    endcase
  end

  always_comb begin
    ext_d       = ext_reg_q;
    neg_d       = neg_reg_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      ext_d       = ext_comb;
      neg_d       = ext_comb[OUT_W-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_reg_q   <= '0;
      neg_reg_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ext_reg_q   <= ext_d;
      neg_reg_q   <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ext_q     = ext_reg_q;
  assign neg_q     = neg_reg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Self-checking bench for sign_extend_unit against an arithmetic reference model.
module tb_sign_extend_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imm;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] ext_comb;
  logic [31:0] ext_q;
  logic        out_valid;
  logic        neg_q;

  int total;
  int bad;

  sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .imm      (imm),
    .mode     (mode),
    .in_valid (in_valid),
    .ext_comb (ext_comb),
    .ext_q    (ext_q),
    .out_valid(out_valid),
    .neg_q    (neg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value interpreted as an integer, scaled, then truncated to 32 bits.
  function automatic logic [31:0] model(input logic [15:0] i, input logic [1:0] m);
    longint sval;
    longint uval;
    longint r;
    logic [63:0] bits;
    uval = longint'(i);
    sval = (uval >= 32768) ? uval - 65536 : uval;
    case (m)
      2'd0:    r = sval;
      2'd1:    r = uval;
      2'd2:    r = sval * 4;
      default: r = uval * 65536;
    endcase
    bits = r;
    return bits[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; imm = 16'hFFFF; mode = 2'd0;
    #1;
    total++;
    if (ext_comb !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL reset_comb got=%h want=ffffffff", ext_comb);
    end
    tick(); tick();
    total++;
    if (ext_q !== 32'h0 || out_valid !== 1'b0 || neg_q !== 1'b0) begin
      bad++; $display("FAIL reset_state got ext_q=%h vld=%b neg=%b want 0/0/0", ext_q, out_valid, neg_q);
    end
    total++;
    if (ext_comb !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL reset_comb_hold got=%h want=ffffffff", ext_comb);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_comb_sign();
    logic [15:0] tbl_in [5];
    logic [31:0] tbl_out[5];
    tbl_in  = '{16'h0000, 16'h000C, 16'h0010, 16'hFFFF, 16'hFFF1};
    tbl_out = '{32'h00000000, 32'h0000000C, 32'h00000010, 32'hFFFFFFFF, 32'hFFFFFFF1};
    mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      imm = tbl_in[k];
      #2;
      total++;
      if (ext_comb !== tbl_out[k]) begin
        bad++; $display("FAIL comb_sign imm=%h got=%h want=%h", tbl_in[k], ext_comb, tbl_out[k]);
      end
    end
  endtask

  task automatic test_modes();
    logic [31:0] want[4];
    want = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFC, 32'hFFFF0000};
    imm = 16'hFFFF;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      #2;
      total++;
      if (ext_comb !== want[m]) begin
        bad++; $display("FAIL mode_%0d got=%h want=%h", m, ext_comb, want[m]);
      end
    end
    // imm=0 is zero in every mode
    imm = 16'h0000;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      #2;
      total++;
      if (ext_comb !== 32'h0) begin
        bad++; $display("FAIL zero_mode_%0d got=%h want=00000000", m, ext_comb);
      end
    end
  endtask

  task automatic test_boundaries();
    imm = 16'h7FFF; mode = 2'd2; in_valid = 1'b0;
    #1;
    total++;
    if (ext_comb !== 32'h0001FFFC) begin
      bad++; $display("FAIL branch_max got=%h want=0001fffc", ext_comb);
    end
    imm = 16'h8000; mode = 2'd0; in_valid = 1'b1;
    #1;
    total++;
    if (ext_comb !== 32'hFFFF8000) begin
      bad++; $display("FAIL most_neg_comb got=%h want=ffff8000", ext_comb);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (ext_q !== 32'hFFFF8000 || neg_q !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL most_neg_reg got ext_q=%h neg=%b vld=%b want ffff8000/1/1", ext_q, neg_q, out_valid);
    end
  endtask

  task automatic test_pipeline();
    imm = 16'h000C; mode = 2'd0; in_valid = 1'b1;
    tick();
    total++;
    if (ext_q !== 32'h0000000C || out_valid !== 1'b1 || neg_q !== 1'b0) begin
      bad++; $display("FAIL pipe_capture got ext_q=%h vld=%b neg=%b want 0000000c/1/0", ext_q, out_valid, neg_q);
    end
    in_valid = 1'b0; imm = 16'hABCD; mode = 2'd3;
    tick();
    total++;
    if (ext_q !== 32'h0000000C || out_valid !== 1'b0) begin
      bad++; $display("FAIL pipe_hold got ext_q=%h vld=%b want 0000000c/0", ext_q, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    imm = 16'h1234; mode = 2'd1; in_valid = 1'b1;
    tick();
    rst = 1'b1; imm = 16'hFFFF; mode = 2'd0;
    tick();
    total++;
    if (ext_q !== 32'h0 || out_valid !== 1'b0 || neg_q !== 1'b0) begin
      bad++; $display("FAIL reset_mid got ext_q=%h vld=%b neg=%b want 0/0/0", ext_q, out_valid, neg_q);
    end
    total++;
    if (ext_comb !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL reset_mid_comb got=%h want=ffffffff", ext_comb);
    end
    rst = 1'b0;
    tick();
    total++;
    if (ext_q !== 32'hFFFFFFFF || out_valid !== 1'b1 || neg_q !== 1'b1) begin
      bad++; $display("FAIL after_reset got ext_q=%h vld=%b neg=%b want ffffffff/1/1", ext_q, out_valid, neg_q);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins [3];
    logic [1:0]  mds [3];
    logic [31:0] outs[3];
    ins  = '{16'h0001, 16'hFFFE, 16'h1234};
    mds  = '{2'd0, 2'd0, 2'd3};
    outs = '{32'h00000001, 32'hFFFFFFFE, 32'h12340000};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imm = ins[k]; mode = mds[k];
      tick();
      total++;
      if (ext_q !== outs[k] || out_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got ext_q=%h vld=%b want %h/1", k, ext_q, out_valid, outs[k]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_q;
    logic        exp_vld;
    logic        exp_neg;
    exp_q = ext_q; exp_neg = neg_q; exp_vld = out_valid;
    for (int n = 0; n < 300; n++) begin
      imm      = 16'($urandom);
      mode     = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 19) == 0);
      #1;
      total++;
      if (ext_comb !== model(imm, mode)) begin
        bad++; $display("FAIL rand_comb imm=%h mode=%0d got=%h want=%h", imm, mode, ext_comb, model(imm, mode));
      end
      if (rst) begin
        exp_q = 32'h0; exp_neg = 1'b0; exp_vld = 1'b0;
      end else if (in_valid) begin
        exp_q = model(imm, mode); exp_neg = exp_q[31]; exp_vld = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
      @(posedge clk); #1;
      total++;
      if (ext_q !== exp_q || out_valid !== exp_vld || neg_q !== exp_neg) begin
        bad++; $display("FAIL rand_reg n=%0d got %h/%b/%b want %h/%b/%b", n, ext_q, out_valid, neg_q, exp_q, exp_vld, exp_neg);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; imm = '0; mode = '0; in_valid = 1'b0;
    test_reset();
    test_comb_sign();
    test_modes();
    test_boundaries();
    test_pipeline();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sign_extend_unit.md
Name: sign_extend_unit

Overview:
- Immediate-extension block for the MIPS-style datapath decode stage.
- Widens a 16-bit instruction immediate to a 32-bit operand.
- Provides a zero-latency combinational result for the ALU-operand mux and a registered copy with valid flag for the pipelined decode/execute boundary.
- Supports sign-extend, zero-extend, branch-offset (sign-extend, shift left 2) and load-upper forms.

Parameters:
- IN_W, 16, immediate input width; must be at least 2 and at most OUT_W/2.
- OUT_W, 32, extended output width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imm  input  IN_W  raw immediate field, two's complement when signed.
- mode  input  2  extension mode: 00 sign, 01 zero, 10 branch, 11 upper.
- in_valid  input  1  qualifies imm/mode for capture into the output register.
- ext_comb  output  OUT_W  combinational extended value of current imm/mode.
- ext_q  output  OUT_W  registered extended value.
- out_valid  output  1  ext_q holds a result captured from a valid input.
- neg_q  output  1  registered MSB of ext_q (result is negative).

Behaviour:
- Mode 00, sign-extend: replicate imm[IN_W-1] into bits OUT_W-1..IN_W; low bits equal imm.
- Mode 01, zero-extend: upper OUT_W-IN_W bits are 0; low bits equal imm.
- Mode 10, branch: sign-extend as mode 00, then shift left 2; bits 1..0 are 0; bits shifted out are discarded.
- Mode 11, upper: imm placed in bits OUT_W-1..OUT_W-IN_W; all lower bits are 0.
- ext_comb is purely combinational, with zero latency from imm or mode.
  - It is independent of clk, rst and in_valid.
  - It is valid from time zero, including during reset.
- On each rising clk edge:
  - If rst=1: ext_q<=0, neg_q<=0, out_valid<=0. Reset has priority over in_valid.
  - Else if in_valid=1: ext_q<=ext_comb, neg_q<=ext_comb[OUT_W-1], out_valid<=1.
  - Else: ext_q and neg_q hold their value, and out_valid<=0.
- Latency is one cycle from in_valid to out_valid; a new value can be accepted every cycle with no backpressure.
- Reset mid-stream discards the pending result; the first valid input after reset deasserts produces out_valid on the following edge.
- Boundary cases:
  - imm=0 gives 0 in every mode.
  - Most-negative imm (only the MSB set) sign-extends to all ones above bit IN_W-2.
  - imm all ones in mode 00 gives all ones in the output.
- No X propagation on the registered outputs after reset.
- Outputs are deterministic for any defined imm/mode.

Test Plan:
- Combinational sign path, mode=00, imm stepped every 2 time units → ext_comb:
  - 0x0000 → 0x00000000
  - 0x000C (12) → 0x0000000C
  - 0x0010 (16) → 0x00000010
  - 0xFFFF (-1) → 0xFFFFFFFF
  - 0xFFF1 (-15) → 0xFFFFFFF1
- Other modes with imm=0xFFFF:
  - mode=01 → 0x0000FFFF
  - mode=10 → 0xFFFFFFFC
  - mode=11 → 0xFFFF0000
- Boundaries:
  - imm=0x8000, mode=00 → 0xFFFF8000, neg_q=1 after capture.
  - imm=0x7FFF, mode=10 → 0x0001FFFC.
- Pipeline:
  - in_valid=1 with imm=0x000C, mode=00 → next edge ext_q=0x0000000C, out_valid=1.
  - in_valid=0 on the following cycle → out_valid=0, ext_q holds 0x0000000C.
- Reset:
  - rst=1 with in_valid=1, imm=0xFFFF → after the edge, ext_q=0, out_valid=0, neg_q=0.
  - ext_comb still reads 0xFFFFFFFF throughout.
- Back-to-back: in_valid held high over imm 0x0001, 0xFFFE, 0x1234 (mode=11) → ext_q on successive edges reads 0x00000001, 0xFFFFFFFE, 0x12340000, with out_valid=1 throughout.
